// File: rtl/regfile_dp_if.sv
// rtl/regfile_dp_if.sv - bus bundle for the dual-write-port register file
//
// Purpose: groups the read, write, reserve and soft-clear signals of
// regfile_dp. The master side drives addresses, write data and control;
// the slave side (the register file) drives read data, busy flags and
// ClearBusy.
//
// Signals:
//   ReadAddr1/2   master->slave  read port addresses
//   ReadData1/2   slave->master  combinational read data
//   ReadBusy1/2   slave->master  pending-producer flags for the read addresses
//   WriteAddr0/1, WriteData0/1, RegWrite0/1  master->slave  write ports
//   Reserve, ReserveAddr  master->slave  mark a register busy at issue
//   Clear         master->slave  start a soft-clear sweep
//   ClearBusy     slave->master  soft-clear sweep in progress
interface regfile_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadAddr1;
  logic [ADDR_W-1:0] ReadAddr2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              ReadBusy1;
  logic              ReadBusy2;
  logic [ADDR_W-1:0] WriteAddr0;
  logic [DATA_W-1:0] WriteData0;
  logic              RegWrite0;
  logic [ADDR_W-1:0] WriteAddr1;
  logic [DATA_W-1:0] WriteData1;
  logic              RegWrite1;
  logic              Reserve;
  logic [ADDR_W-1:0] ReserveAddr;
  logic              Clear;
  logic              ClearBusy;

  modport master (
    output ReadAddr1, ReadAddr2,
    input  ReadData1, ReadData2, ReadBusy1, ReadBusy2,
    output WriteAddr0, WriteData0, RegWrite0,
    output WriteAddr1, WriteData1, RegWrite1,
    output Reserve, ReserveAddr, Clear,
    input  ClearBusy
  );

  modport slave (
    input  ReadAddr1, ReadAddr2,
    output ReadData1, ReadData2, ReadBusy1, ReadBusy2,
    input  WriteAddr0, WriteData0, RegWrite0,
    input  WriteAddr1, WriteData1, RegWrite1,
    input  Reserve, ReserveAddr, Clear,
    output ClearBusy
  );
endinterface

// File: rtl/regfile_dp.sv
// rtl/regfile_dp.sv - dual-write-port register file with bypass, scoreboard and soft-clear
//
// Purpose: NREG x DATA_W register file with two combinational read ports,
// two write ports (port 1 wins on a same-address collision), same-cycle
// write-to-read forwarding, a per-register busy scoreboard and a sequenced
// soft-clear sweep that zeroes one register per cycle.
//
// Ports:
//   clk    rising-edge clock
//   Reset  asynchronous active-low reset
//   rf     regfile_dp_if.slave bundle (reads, writes, reserve, clear)
module regfile_dp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         Reset,
  regfile_dp_if.slave  rf
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [DATA_W-1:0] regs_q [NREG];

  logic idle;
  logic we0, we1, rsv;
  logic hit1_0, hit1_1, hit2_0, hit2_1;

  // Register 0 is read-only when hardwired to zero.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign idle = (state_q == S_IDLE);

  // Effective update strobes: everything except the sweep is dropped in CLEAR.
  assign we0 = idle && rf.RegWrite0 && writable(rf.WriteAddr0);
  assign we1 = idle && rf.RegWrite1 && writable(rf.WriteAddr1);
  assign rsv = idle && rf.Reserve   && writable(rf.ReserveAddr);

  assign hit1_0 = we0 && (rf.WriteAddr0 == rf.ReadAddr1);
  assign hit1_1 = we1 && (rf.WriteAddr1 == rf.ReadAddr1);
  assign hit2_0 = we0 && (rf.WriteAddr0 == rf.ReadAddr2);
  assign hit2_1 = we1 && (rf.WriteAddr1 == rf.ReadAddr2);

  // Read port 1: port-1 forward, then port-0 forward, then array.
  always_comb begin
    rf.ReadData1 = regs_q[rf.ReadAddr1];
    if (BYPASS != 0) begin
      if (hit1_1)      rf.ReadData1 = rf.WriteData1;
      else if (hit1_0) rf.ReadData1 = rf.WriteData0;
    end
    if (!writable(rf.ReadAddr1)) rf.ReadData1 = '0;
  end

  always_comb begin
    rf.ReadData2 = regs_q[rf.ReadAddr2];
    if (BYPASS != 0) begin
      if (hit2_1)      rf.ReadData2 = rf.WriteData1;
      else if (hit2_0) rf.ReadData2 = rf.WriteData0;
    end
    if (!writable(rf.ReadAddr2)) rf.ReadData2 = '0;
  end

  // A producer writing this cycle resolves the hazard when forwarding is on.
  assign rf.ReadBusy1 = busy_q[rf.ReadAddr1] && !((BYPASS != 0) && (hit1_0 || hit1_1));
  assign rf.ReadBusy2 = busy_q[rf.ReadAddr2] && !((BYPASS != 0) && (hit2_0 || hit2_1));

  assign rf.ClearBusy = (state_q == S_CLEAR);

  // Next-state for FSM, sweep counter and scoreboard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == S_IDLE) begin
      // Writes clear first so a same-address reserve leaves the bit set.
      if (we0) busy_d[rf.WriteAddr0] = 1'b0;
      if (we1) busy_d[rf.WriteAddr1] = 1'b0;
      if (rsv) busy_d[rf.ReserveAddr] = 1'b1;
      if (rf.Clear) begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      busy_d[cnt_q] = 1'b0;
      cnt_d         = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Array storage; port 1 is assigned last so it wins a collision.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (state_q == S_IDLE) begin
      if (we0) regs_q[rf.WriteAddr0] <= rf.WriteData0;
      if (we1) regs_q[rf.WriteAddr1] <= rf.WriteData1;
    end else begin
      regs_q[cnt_q] <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_dp.sv
// tb/tb_regfile_dp.sv - self-checking bench for regfile_dp
module tb_regfile_dp;

  logic clk;
  logic Reset;

  regfile_dp_if #(.DATA_W(32), .ADDR_W(5)) rf ();
  regfile_dp_if #(.DATA_W(32), .ADDR_W(5)) rf_nb ();

  regfile_dp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk   (clk),
    .Reset (Reset),
    .rf    (rf)
  );

  regfile_dp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .Reset (Reset),
    .rf    (rf_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the bypassing DUT.
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  int          m_sweep_left;
  int          m_sweep_idx;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_sweep_left = 0;
    m_sweep_idx  = 0;
  endfunction

  // Applies one rising edge worth of architectural effects.
  function automatic void model_commit();
    if (m_sweep_left > 0) begin
      m_reg[m_sweep_idx]  = 32'h0;
      m_busy[m_sweep_idx] = 1'b0;
      m_sweep_idx++;
      m_sweep_left--;
    end else begin
      if (rf.RegWrite0 && rf.WriteAddr0 != 0) begin
        m_reg[rf.WriteAddr0]  = rf.WriteData0;
        m_busy[rf.WriteAddr0] = 1'b0;
      end
      if (rf.RegWrite1 && rf.WriteAddr1 != 0) begin
        m_reg[rf.WriteAddr1]  = rf.WriteData1;
        m_busy[rf.WriteAddr1] = 1'b0;
      end
      if (rf.Reserve && rf.ReserveAddr != 0) m_busy[rf.ReserveAddr] = 1'b1;
      if (rf.Clear) begin
        m_sweep_left = 32;
        m_sweep_idx  = 0;
      end
    end
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_sweep_left == 0) begin
      if (rf.RegWrite1 && rf.WriteAddr1 == a) return rf.WriteData1;
      if (rf.RegWrite0 && rf.WriteAddr0 == a) return rf.WriteData0;
    end
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (m_sweep_left == 0) begin
      if (rf.RegWrite1 && rf.WriteAddr1 == a) return 1'b0;
      if (rf.RegWrite0 && rf.WriteAddr0 == a) return 1'b0;
    end
    return m_busy[a];
  endfunction

  task automatic idle_inputs();
    rf.RegWrite0 = 1'b0; rf.RegWrite1 = 1'b0;
    rf.Reserve   = 1'b0; rf.Clear     = 1'b0;
    rf.WriteAddr0 = '0; rf.WriteData0 = '0;
    rf.WriteAddr1 = '0; rf.WriteData1 = '0;
    rf.ReserveAddr = '0;
    rf_nb.RegWrite0 = 1'b0; rf_nb.RegWrite1 = 1'b0;
    rf_nb.Reserve   = 1'b0; rf_nb.Clear     = 1'b0;
    rf_nb.WriteAddr0 = '0; rf_nb.WriteData0 = '0;
    rf_nb.WriteAddr1 = '0; rf_nb.WriteData1 = '0;
    rf_nb.ReserveAddr = '0;
  endtask

  // Advance one edge; inputs change #1 after the edge, away from it.
  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rf.ReadAddr1 = '0; rf.ReadAddr2 = '0;
    rf_nb.ReadAddr1 = '0; rf_nb.ReadAddr2 = '0;
    Reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 Reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rf.ReadAddr1 = 5'(a);
      rf.ReadAddr2 = 5'(31 - a);
      #1;
      n_checks += 4;
      if (rf.ReadData1 !== 32'h0) begin n_fail++; $display("FAIL reset_data1 a=%0d got=%h exp=0", a, rf.ReadData1); end
      if (rf.ReadData2 !== 32'h0) begin n_fail++; $display("FAIL reset_data2 a=%0d got=%h exp=0", a, rf.ReadData2); end
      if (rf.ReadBusy1 !== 1'b0 || rf.ReadBusy2 !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy a=%0d got=%b%b exp=00", a, rf.ReadBusy1, rf.ReadBusy2);
      end
      if (rf.ClearBusy !== 1'b0) begin n_fail++; $display("FAIL reset_clearbusy got=%b exp=0", rf.ClearBusy); end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    rf.WriteAddr0 = 5'd5; rf.WriteData0 = 32'hDEADBEEF; rf.RegWrite0 = 1'b1;
    rf.ReadAddr1 = 5'd5;
    #1;
    n_checks++;
    if (rf.ReadData1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rf.ReadData1); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rf.ReadData1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_next_cycle got=%h exp=deadbeef", rf.ReadData1); end
  endtask

  task automatic test_no_bypass();
    idle_inputs();
    rf_nb.WriteAddr0 = 5'd5; rf_nb.WriteData0 = 32'hDEADBEEF; rf_nb.RegWrite0 = 1'b1;
    rf_nb.ReadAddr1 = 5'd5;
    #1;
    n_checks++;
    if (rf_nb.ReadData1 !== 32'h0) begin n_fail++; $display("FAIL nobypass_same_cycle got=%h exp=0", rf_nb.ReadData1); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rf_nb.ReadData1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobypass_next_cycle got=%h exp=deadbeef", rf_nb.ReadData1); end
  endtask

  task automatic test_port_priority();
    idle_inputs();
    rf.WriteAddr0 = 5'd7; rf.WriteData0 = 32'h11111111; rf.RegWrite0 = 1'b1;
    rf.WriteAddr1 = 5'd7; rf.WriteData1 = 32'h22222222; rf.RegWrite1 = 1'b1;
    rf.ReadAddr2 = 5'd7;
    #1;
    n_checks++;
    if (rf.ReadData2 !== 32'h22222222) begin n_fail++; $display("FAIL prio_bypass got=%h exp=22222222", rf.ReadData2); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rf.ReadData2 !== 32'h22222222) begin n_fail++; $display("FAIL prio_stored got=%h exp=22222222", rf.ReadData2); end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    rf.WriteAddr0 = 5'd0; rf.WriteData0 = 32'hFFFFFFFF; rf.RegWrite0 = 1'b1;
    rf.WriteAddr1 = 5'd0; rf.WriteData1 = 32'hFFFFFFFF; rf.RegWrite1 = 1'b1;
    rf.Reserve = 1'b1; rf.ReserveAddr = 5'd0;
    rf.ReadAddr1 = 5'd0;
    #1;
    n_checks += 2;
    if (rf.ReadData1 !== 32'h0) begin n_fail++; $display("FAIL r0_data_same got=%h exp=0", rf.ReadData1); end
    if (rf.ReadBusy1 !== 1'b0) begin n_fail++; $display("FAIL r0_busy_same got=%b exp=0", rf.ReadBusy1); end
    tick();
    idle_inputs();
    #1;
    n_checks += 2;
    if (rf.ReadData1 !== 32'h0) begin n_fail++; $display("FAIL r0_data_after got=%h exp=0", rf.ReadData1); end
    if (rf.ReadBusy1 !== 1'b0) begin n_fail++; $display("FAIL r0_busy_after got=%b exp=0", rf.ReadBusy1); end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    rf.ReadAddr1 = 5'd9;
    rf.Reserve = 1'b1; rf.ReserveAddr = 5'd9;
    #1;
    n_checks++;
    if (rf.ReadBusy1 !== 1'b0) begin n_fail++; $display("FAIL sb_reserve_same got=%b exp=0", rf.ReadBusy1); end
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (rf.ReadBusy1 !== 1'b1) begin n_fail++; $display("FAIL sb_reserved k=%0d got=%b exp=1", k, rf.ReadBusy1); end
      tick();
    end
    rf.WriteAddr1 = 5'd9; rf.WriteData1 = 32'h0000A5A5; rf.RegWrite1 = 1'b1;
    #1;
    n_checks += 2;
    if (rf.ReadBusy1 !== 1'b0) begin n_fail++; $display("FAIL sb_write_bypass got=%b exp=0", rf.ReadBusy1); end
    if (rf.ReadData1 !== 32'h0000A5A5) begin n_fail++; $display("FAIL sb_write_data got=%h exp=0000a5a5", rf.ReadData1); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rf.ReadBusy1 !== 1'b0) begin n_fail++; $display("FAIL sb_after_write got=%b exp=0", rf.ReadBusy1); end
    rf.Reserve = 1'b1; rf.ReserveAddr = 5'd9;
    rf.WriteAddr0 = 5'd9; rf.WriteData0 = 32'h00005A5A; rf.RegWrite0 = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_checks += 2;
    if (rf.ReadBusy1 !== 1'b1) begin n_fail++; $display("FAIL sb_reserve_wins got=%b exp=1", rf.ReadBusy1); end
    if (rf.ReadData1 !== 32'h00005A5A) begin n_fail++; $display("FAIL sb_reserve_wins_data got=%h exp=00005a5a", rf.ReadData1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle_inputs();
      rf.RegWrite0   = ($urandom_range(0, 1) == 1);
      rf.WriteAddr0  = 5'($urandom_range(0, 7));
      rf.WriteData0  = $urandom;
      rf.RegWrite1   = ($urandom_range(0, 2) == 0);
      rf.WriteAddr1  = 5'($urandom_range(0, 7));
      rf.WriteData1  = $urandom;
      rf.Reserve     = ($urandom_range(0, 1) == 1);
      rf.ReserveAddr = 5'($urandom_range(0, 7));
      rf.ReadAddr1   = 5'($urandom_range(0, 7));
      rf.ReadAddr2   = 5'($urandom_range(0, 31));
      #1;
      n_checks += 4;
      if (rf.ReadData1 !== exp_data(rf.ReadAddr1)) begin
        n_fail++; $display("FAIL rand_data1 c=%0d a=%0d got=%h exp=%h", c, rf.ReadAddr1, rf.ReadData1, exp_data(rf.ReadAddr1));
      end
      if (rf.ReadData2 !== exp_data(rf.ReadAddr2)) begin
        n_fail++; $display("FAIL rand_data2 c=%0d a=%0d got=%h exp=%h", c, rf.ReadAddr2, rf.ReadData2, exp_data(rf.ReadAddr2));
      end
      if (rf.ReadBusy1 !== exp_busy(rf.ReadAddr1)) begin
        n_fail++; $display("FAIL rand_busy1 c=%0d a=%0d got=%b exp=%b", c, rf.ReadAddr1, rf.ReadBusy1, exp_busy(rf.ReadAddr1));
      end
      if (rf.ReadBusy2 !== exp_busy(rf.ReadAddr2)) begin
        n_fail++; $display("FAIL rand_busy2 c=%0d a=%0d got=%b exp=%b", c, rf.ReadAddr2, rf.ReadBusy2, exp_busy(rf.ReadAddr2));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic load_all();
    for (int a = 1; a < 32; a++) begin
      idle_inputs();
      rf.WriteAddr0 = 5'(a); rf.WriteData0 = 32'h01010101 * a; rf.RegWrite0 = 1'b1;
      rf.Reserve = (a % 3 == 0); rf.ReserveAddr = 5'(a);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_soft_clear();
    int n;
    load_all();
    rf.Clear = 1'b1;
    rf.WriteAddr1 = 5'd31; rf.WriteData1 = 32'hCAFEF00D; rf.RegWrite1 = 1'b1;
    tick();
    idle_inputs();
    n = 0;
    while (rf.ClearBusy === 1'b1 && n < 40) begin
      idle_inputs();
      if (n == 3) begin
        rf.WriteAddr0 = 5'd3; rf.WriteData0 = 32'h12345678; rf.RegWrite0 = 1'b1;
        rf.Reserve = 1'b1; rf.ReserveAddr = 5'd4;
        rf.Clear = 1'b1;
      end
      rf.ReadAddr1 = 5'd31;
      rf.ReadAddr2 = (n == 3) ? 5'd3 : 5'($urandom_range(0, 31));
      #1;
      n_checks += 3;
      if (rf.ReadData1 !== exp_data(rf.ReadAddr1)) begin
        n_fail++; $display("FAIL sweep_data1 n=%0d got=%h exp=%h", n, rf.ReadData1, exp_data(rf.ReadAddr1));
      end
      if (rf.ReadData2 !== exp_data(rf.ReadAddr2)) begin
        n_fail++; $display("FAIL sweep_data2 n=%0d a=%0d got=%h exp=%h", n, rf.ReadAddr2, rf.ReadData2, exp_data(rf.ReadAddr2));
      end
      if (rf.ReadBusy2 !== exp_busy(rf.ReadAddr2)) begin
        n_fail++; $display("FAIL sweep_busy2 n=%0d a=%0d got=%b exp=%b", n, rf.ReadAddr2, rf.ReadBusy2, exp_busy(rf.ReadAddr2));
      end
      tick();
      n++;
    end
    idle_inputs();
    n_checks++;
    if (n != 32) begin n_fail++; $display("FAIL sweep_length got=%0d exp=32", n); end
    for (int a = 0; a < 32; a++) begin
      rf.ReadAddr1 = 5'(a);
      #1;
      n_checks += 2;
      if (rf.ReadData1 !== 32'h0) begin n_fail++; $display("FAIL post_sweep_data a=%0d got=%h exp=0", a, rf.ReadData1); end
      if (rf.ReadBusy1 !== 1'b0) begin n_fail++; $display("FAIL post_sweep_busy a=%0d got=%b exp=0", a, rf.ReadBusy1); end
    end
    n_checks++;
    if (rf.ClearBusy !== 1'b0) begin n_fail++; $display("FAIL post_sweep_clearbusy got=%b exp=0", rf.ClearBusy); end
  endtask

  task automatic test_clear_reset();
    load_all();
    rf.Clear = 1'b1;
    tick();
    idle_inputs();
    repeat (10) tick();
    n_checks++;
    if (rf.ClearBusy !== 1'b1) begin n_fail++; $display("FAIL midsweep_clearbusy got=%b exp=1", rf.ClearBusy); end
    #2 Reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rf.ClearBusy !== 1'b0) begin n_fail++; $display("FAIL abort_clearbusy got=%b exp=0", rf.ClearBusy); end
    for (int a = 0; a < 32; a++) begin
      rf.ReadAddr1 = 5'(a);
      rf.ReadAddr2 = 5'(a);
      #1;
      n_checks += 2;
      if (rf.ReadData1 !== 32'h0) begin n_fail++; $display("FAIL abort_data a=%0d got=%h exp=0", a, rf.ReadData1); end
      if (rf.ReadBusy2 !== 1'b0) begin n_fail++; $display("FAIL abort_busy a=%0d got=%b exp=0", a, rf.ReadBusy2); end
    end
    @(posedge clk);
    #1 Reset = 1'b1;
    rf.WriteAddr0 = 5'd12; rf.WriteData0 = 32'h0BADF00D; rf.RegWrite0 = 1'b1;
    tick();
    idle_inputs();
    rf.ReadAddr1 = 5'd12;
    #1;
    n_checks += 2;
    if (rf.ReadData1 !== 32'h0BADF00D) begin n_fail++; $display("FAIL post_abort_write got=%h exp=0badf00d", rf.ReadData1); end
    if (rf.ClearBusy !== 1'b0) begin n_fail++; $display("FAIL post_abort_clearbusy got=%b exp=0", rf.ClearBusy); end
  endtask

  initial begin
    Reset = 1'b0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_no_bypass();
    test_port_priority();
    test_zero_reg();
    test_scoreboard();
    test_random();
    test_soft_clear();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
